// File: rtl/x_top_uart_loopback.sv
// Buffered UART loopback: rx bytes go through a FIFO and are echoed, case-swapped,
// held or flushed under control of a runtime mode input.

module x_uart_rx #(
  parameter int unsigned p_clk_hz = 1000000,
  parameter int unsigned p_baud   = 9600
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);
  localparam int unsigned Cpb = p_clk_hz / p_baud;
  localparam int unsigned Cw  = $clog2(Cpb);
  localparam logic [Cw-1:0] CntFull = Cw'(Cpb - 1);
  localparam logic [Cw-1:0] CntHalf = Cw'(Cpb / 2 - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [1:0]    state_q, state_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;

  assign rx_s    = sync_q[1];
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      // Re-check the start bit at mid-bit to reject glitches.
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          state_d = StIdle;
          valid_d = rx_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q  <= 2'b11;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

module x_uart_tx #(
  parameter int unsigned p_clk_hz = 1000000,
  parameter int unsigned p_baud   = 9600
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx
);
  localparam int unsigned Cpb = p_clk_hz / p_baud;
  localparam int unsigned Cw  = $clog2(Cpb);
  localparam logic [Cw-1:0] CntFull = Cw'(Cpb - 1);

  logic          busy_q, busy_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  assign o_accept = !busy_q;
  assign o_tx     = tx_q;

  // bit_q counts periods: 0 is start, 1..8 data, 9 stop.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (!busy_q) begin
      if (i_valid) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        shift_d = {1'b1, i_data};
        cnt_d   = '0;
        bit_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntFull) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
endmodule

module x_top_uart_loopback #(
  parameter int unsigned p_clk_hz = 1000000,
  parameter int unsigned p_baud   = 9600,
  parameter int unsigned p_depth  = 16,
  localparam int unsigned LW      = $clog2(p_depth) + 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_rx,
  output logic          o_tx,
  input  logic [1:0]    i_mode,
  input  logic          i_clr_ovf,
  output logic [LW-1:0] o_level,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_overflow
);
  localparam int unsigned Aw = LW - 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic          tx_accept;
  logic [7:0]    tx_data;
  logic [7:0]    head;
  logic          is_alpha;
  logic          flush, push_req, push, pop, drop;
  logic [LW-1:0] wr_q, rd_q;
  logic          ovf_q;
  logic [7:0]    mem_q [p_depth];

  x_uart_rx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_rx (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_rx    (i_rx),
    .o_valid (rx_valid),
    .o_data  (rx_data)
  );

  x_uart_tx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_tx (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_valid  (tx_valid),
    .i_data   (tx_data),
    .o_accept (tx_accept),
    .o_tx     (o_tx)
  );

  assign o_level    = wr_q - rd_q;
  assign o_empty    = (wr_q == rd_q);
  assign o_full     = (wr_q[Aw-1:0] == rd_q[Aw-1:0]) && (wr_q[Aw] != rd_q[Aw]);
  assign o_overflow = ovf_q;

  assign flush    = (i_mode == 2'd3);
  assign push_req = rx_valid && !flush;
  assign tx_valid = !o_empty && !i_mode[1];
  assign pop      = tx_valid && tx_accept;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push     = push_req && (!o_full || pop);
  assign drop     = push_req && o_full && !pop;

  always_comb begin
    head     = mem_q[rd_q[Aw-1:0]];
    is_alpha = ((head >= 8'h41) && (head <= 8'h5A)) || ((head >= 8'h61) && (head <= 8'h7A));
    tx_data  = ((i_mode == 2'd1) && is_alpha) ? (head ^ 8'h20) : head;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[Aw-1:0]] <= rx_data;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (i_clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_x_top_uart_loopback.sv
// Directed bench for x_top_uart_loopback: 10 clk/bit, 4-deep FIFO, frames decoded off o_tx.

module tb_x_top_uart_loopback;
  logic       clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic       tx;
  logic [1:0] mode;
  logic       clr_ovf;
  logic [2:0] level;
  logic       empty, full, ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_frame_err = 0;

  logic [7:0] frames [$];
  bit         mon_busy;
  int         mon_cnt;
  logic [7:0] mon_byte;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs [10];

  x_top_uart_loopback #(
    .p_clk_hz (1000000),
    .p_baud   (100000),
    .p_depth  (4)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_rx       (rx),
    .o_tx       (tx),
    .i_mode     (mode),
    .i_clr_ovf  (clr_ovf),
    .o_level    (level),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Line monitor: decodes 8N1 frames on o_tx by sampling at mid-bit.
  initial begin
    mon_busy = 1'b0;
    mon_cnt  = 0;
    mon_byte = '0;
    forever begin
      @(negedge clk);
      if (nrst !== 1'b1) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (tx === 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
          mon_byte[(mon_cnt - 15) / 10] = tx;
        if (mon_cnt == 95) begin
          if (tx !== 1'b1) n_frame_err++;
          frames.push_back(mon_byte);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hDEAD;
    for (int i = 0; i < 400; i++) begin
      if (frames.size() > 0) begin
        got = {24'h0, frames.pop_front()};
        break;
      end
      @(negedge clk);
    end
    check(name, got, {24'h0, exp});
  endtask

  initial begin
    int lat;
    int t;
    vecs[0] = '{2'd1, 8'h61, 8'h41};
    vecs[1] = '{2'd1, 8'h5A, 8'h7A};
    vecs[2] = '{2'd1, 8'h33, 8'h33};
    vecs[3] = '{2'd1, 8'h40, 8'h40};
    vecs[4] = '{2'd1, 8'h5B, 8'h5B};
    vecs[5] = '{2'd1, 8'h60, 8'h60};
    vecs[6] = '{2'd1, 8'h7B, 8'h7B};
    vecs[7] = '{2'd1, 8'h41, 8'h61};
    vecs[8] = '{2'd1, 8'h7A, 8'h5A};
    vecs[9] = '{2'd0, 8'h61, 8'h61};

    rx      = 1'b1;
    mode    = 2'd0;
    clr_ovf = 1'b0;
    nrst    = 1'b1;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", {31'h0, tx}, 1);
    check("reset level", {29'h0, level}, 0);
    check("reset empty", {31'h0, empty}, 1);
    check("reset full", {31'h0, full}, 0);
    check("reset ovf", {31'h0, ovf}, 0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 echo with latency measured from the rx valid pulse.
    lat = 99;
    fork
      send_byte(8'h55);
      begin
        for (t = 0; t < 200; t++) begin
          @(negedge clk);
          if (dut.rx_valid) break;
        end
        if (t < 200) begin
          lat = 0;
          while (tx !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
          end
        end
      end
    join
    check("echo latency le 2", {31'h0, lat <= 2}, 1);
    expect_frame("echo 55", 8'h55);
    repeat (5) @(negedge clk);
    check("echo level", {29'h0, level}, 0);
    check("echo ovf", {31'h0, ovf}, 0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      send_byte(vecs[i].din);
      expect_frame($sformatf("vec%0d m%0d %02h", i, vecs[i].mode, vecs[i].din), vecs[i].dout);
      check($sformatf("vec%0d level", i), {29'h0, level}, 0);
    end

    // Hold then release.
    mode = 2'd2;
    for (int i = 1; i <= 3; i++) send_byte(8'(i));
    repeat (20) @(negedge clk);
    check("hold level", {29'h0, level}, 3);
    check("hold no tx", frames.size() + int'(mon_busy), 0);
    check("hold tx idle", {31'h0, tx}, 1);
    mode = 2'd0;
    for (int i = 1; i <= 3; i++) expect_frame($sformatf("release %0d", i), 8'(i));
    repeat (5) @(negedge clk);
    check("release empty", {31'h0, empty}, 1);

    // Overflow, clear, and set-beats-clear.
    mode = 2'd2;
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
    repeat (5) @(negedge clk);
    check("ovf full", {31'h0, full}, 1);
    check("ovf level", {29'h0, level}, 4);
    check("ovf flag", {31'h0, ovf}, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf cleared", {31'h0, ovf}, 0);
    clr_ovf = 1'b1;
    fork
      send_byte(8'h16);
      begin
        for (t = 0; t < 200; t++) begin
          @(negedge clk);
          if (dut.rx_valid) break;
        end
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf set wins over clear", {31'h0, ovf}, 1);
      end
    join
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf cleared again", {31'h0, ovf}, 0);
    mode = 2'd0;
    for (int i = 0; i < 4; i++) expect_frame($sformatf("drain %0d", i), 8'h10 + 8'(i));
    repeat (300) @(negedge clk);
    check("dropped bytes absent", frames.size(), 0);

    // Flush.
    mode = 2'd2;
    for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i));
    repeat (3) @(negedge clk);
    check("pre-flush level", {29'h0, level}, 3);
    mode = 2'd3;
    @(negedge clk);
    mode = 2'd2;
    check("flush level", {29'h0, level}, 0);
    check("flush empty", {31'h0, empty}, 1);
    mode = 2'd3;
    send_byte(8'h24);
    repeat (3) @(negedge clk);
    check("flush rx level", {29'h0, level}, 0);
    check("flush rx ovf", {31'h0, ovf}, 0);
    mode = 2'd0;
    repeat (150) @(negedge clk);
    check("flush nothing sent", frames.size(), 0);

    // Reset in the middle of a transmitted frame with a full, overflowed FIFO.
    mode = 2'd2;
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
    repeat (3) @(negedge clk);
    check("pre-reset ovf", {31'h0, ovf}, 1);
    mode = 2'd0;
    for (t = 0; t < 50 && tx !== 1'b0; t++) @(negedge clk);
    repeat (30) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midframe reset tx", {31'h0, tx}, 1);
    check("midframe reset level", {29'h0, level}, 0);
    check("midframe reset empty", {31'h0, empty}, 1);
    check("midframe reset full", {31'h0, full}, 0);
    check("midframe reset ovf", {31'h0, ovf}, 0);
    repeat (3) @(negedge clk);
    check("reset held tx", {31'h0, tx}, 1);
    nrst = 1'b1;
    frames.delete();
    repeat (5) @(negedge clk);
    send_byte(8'hA5);
    expect_frame("post-reset A5", 8'hA5);
    repeat (150) @(negedge clk);
    check("post-reset no extra", frames.size(), 0);
    check("stop bits", n_frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
